subneg_prog_loader: RTL and testbench



---
 rtl/subneg_prog_loader.sv | 166 ++++++++++++++++
 tb/tb_subneg_prog_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/subneg_prog_loader.sv
// Byte-wide program loader for the SUBNEG core: length byte, N data bytes and an
// optional checksum byte (LOADER_CHECKSUM_EN) over an async strobe handshake.
module subneg_prog_loader #(
    parameter int WORDS  = 22,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              strobe,
    input  logic [7:0]        byte_in,
    output logic              ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_SUM, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE, S_ERR} state_t;
`endif

    state_t              r_state;
    logic                r_s1, r_s2, r_s3;
    logic                r_load_d;
    logic                r_ack, r_mem_we, r_cpu_run, r_busy, r_err;
    logic [ADDR_W-1:0]   r_waddr, r_addr, r_last;
    logic [7:0]          r_wdata;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          r_sum;
    logic [7:0]          w_sum_next;
    assign w_sum_next = r_sum + byte_in;
`endif

    logic       w_sev, w_loading, w_accept, w_req_rise, w_len_bad;
    logic [7:0] w_len_m1;

    assign w_sev      = r_s2 & ~r_s3;
`ifdef LOADER_CHECKSUM_EN
    assign w_loading  = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_SUM);
`else
    assign w_loading  = (r_state == S_LEN) || (r_state == S_DATA);
`endif
    // An abort (load_req low) takes priority over a byte arriving in the same cycle.
    assign w_accept   = w_sev & w_loading & load_req;
    assign w_req_rise = load_req & ~r_load_d;
    assign w_len_bad  = (byte_in == 8'd0) || (32'(byte_in) > WORDS);
    assign w_len_m1   = byte_in - 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_s3      <= 1'b0;
            r_load_d  <= 1'b0;
            r_ack     <= 1'b0;
            r_mem_we  <= 1'b0;
            r_cpu_run <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= 8'd0;
            r_addr    <= '0;
            r_last    <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum     <= 8'd0;
`endif
        end else begin
            r_s1     <= strobe;
            r_s2     <= r_s1;
            r_s3     <= r_s2;
            r_load_d <= load_req;
            r_mem_we <= 1'b0;

            if (w_accept)
                r_ack <= 1'b1;
            else if (!r_s2)
                r_ack <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (load_req) begin
                        r_state   <= S_LEN;
                        r_cpu_run <= 1'b0;
                        r_busy    <= 1'b1;
                        r_err     <= 1'b0;
                    end else begin
                        r_cpu_run <= 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    if (w_req_rise) begin
                        r_state   <= S_LEN;
                        r_cpu_run <= 1'b0;
                        r_busy    <= 1'b1;
                        r_err     <= 1'b0;
                    end
                end
                default: begin
                    if (!load_req) begin
                        r_state <= S_ERR;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else if (w_sev) begin
                        if (r_state == S_LEN) begin
`ifdef LOADER_CHECKSUM_EN
                            r_sum <= byte_in;
`endif
                            if (w_len_bad) begin
                                r_state <= S_ERR;
                                r_busy  <= 1'b0;
                                r_err   <= 1'b1;
                            end else begin
                                r_state <= S_DATA;
                                r_addr  <= '0;
                                r_last  <= ADDR_W'(w_len_m1);
                            end
                        end else if (r_state == S_DATA) begin
                            r_mem_we <= 1'b1;
                            r_waddr  <= r_addr;
                            r_wdata  <= byte_in;
                            r_addr   <= r_addr + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                            r_sum    <= w_sum_next;
                            if (r_addr == r_last)
                                r_state <= S_SUM;
`else
                            if (r_addr == r_last) begin
                                r_state   <= S_DONE;
                                r_busy    <= 1'b0;
                                r_cpu_run <= 1'b1;
                            end
`endif
                        end else begin
`ifdef LOADER_CHECKSUM_EN
                            r_sum  <= w_sum_next;
                            r_busy <= 1'b0;
                            if (w_sum_next == 8'd0) begin
                                r_state   <= S_DONE;
                                r_cpu_run <= 1'b1;
                            end else begin
                                r_state <= S_ERR;
                                r_err   <= 1'b1;
                            end
`endif
                        end
                    end
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign mem_we    = r_mem_we;
    assign mem_waddr = r_waddr;
    assign mem_wdata = r_wdata;
    assign cpu_run   = r_cpu_run;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_subneg_prog_loader.sv
// Directed bench for subneg_prog_loader: expected memory writes go into a queue that a
// monitor drains on every mem_we; status outputs are checked against hand-computed values.
module tb_subneg_prog_loader;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_req = 1'b0;
    logic              strobe = 1'b0;
    logic [7:0]        byte_in = 8'd0;
    logic              ack, mem_we, cpu_run, busy, err;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    int n_vec = 0;
    int n_err = 0;
    logic [ADDR_W+7:0] exp_q[$];

    subneg_prog_loader #(.WORDS(22), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .strobe(strobe), .byte_in(byte_in),
        .ack(ack), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL write: unexpected mem[%0d]=0x%02h, expected no write", mem_waddr, mem_wdata);
            end else begin
                logic [ADDR_W+7:0] e;
                e = exp_q.pop_front();
                if ({mem_waddr, mem_wdata} !== e) begin
                    n_err++;
                    $display("FAIL write: got mem[%0d]=0x%02h, expected mem[%0d]=0x%02h",
                             mem_waddr, mem_wdata, e[ADDR_W+7:8], e[7:0]);
                end else begin
                    $display("ok   write mem[%0d]=0x%02h", mem_waddr, mem_wdata);
                end
            end
        end
    end

    task automatic expect_write(input int addr, input logic [7:0] data);
        exp_q.push_back({ADDR_W'(addr), data});
    endtask

    // One host byte: strobe goes high at a falling edge, so the next rising edge is k.
    task automatic send_byte(input logic [7:0] b, input logic e_we, input logic e_ack,
                             input logic e_busy, input logic e_run, input string tag);
        @(negedge clk); byte_in = b;
        @(negedge clk); strobe = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check({tag, " mem_we@k+2"}, 32'(mem_we), 32'(e_we));
        check({tag, " ack@k+2"}, 32'(ack), 32'(e_ack));
        check({tag, " busy"}, 32'(busy), 32'(e_busy));
        check({tag, " cpu_run"}, 32'(cpu_run), 32'(e_run));
        @(negedge clk);
        @(negedge clk); strobe = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check({tag, " ack low"}, 32'(ack), 32'd0);
        @(negedge clk);
    endtask

    task automatic start_load(input string tag);
        @(negedge clk); load_req = 1'b0;
        @(negedge clk); load_req = 1'b1;
        @(posedge clk); #1;
        check({tag, " LEN busy"}, 32'(busy), 32'd1);
        check({tag, " LEN cpu_run"}, 32'(cpu_run), 32'd0);
        check({tag, " LEN err"}, 32'(err), 32'd0);
    endtask

    task automatic check_status(input string tag, input logic e_run, input logic e_busy, input logic e_err);
        check({tag, " cpu_run"}, 32'(cpu_run), 32'(e_run));
        check({tag, " busy"}, 32'(busy), 32'(e_busy));
        check({tag, " err"}, 32'(err), 32'(e_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state and cpu_run release with no load requested
        #12;
        check_status("reset", 1'b0, 1'b0, 1'b0);
        check("reset ack", 32'(ack), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("cpu_run after reset", 32'(cpu_run), 32'd1);
        repeat (3) @(posedge clk);

`ifdef LOADER_CHECKSUM_EN
        start_load("good");
        send_byte(8'd3, 1'b0, 1'b1, 1'b1, 1'b0, "good len");
        expect_write(0, 8'h12); send_byte(8'h12, 1'b1, 1'b1, 1'b1, 1'b0, "good d0");
        expect_write(1, 8'h13); send_byte(8'h13, 1'b1, 1'b1, 1'b1, 1'b0, "good d1");
        expect_write(2, 8'h03); send_byte(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, "good d2");
        send_byte(8'hD5, 1'b0, 1'b1, 1'b0, 1'b1, "good sum");
        check_status("good done", 1'b1, 1'b0, 1'b0);

        start_load("badsum");
        send_byte(8'd3, 1'b0, 1'b1, 1'b1, 1'b0, "badsum len");
        expect_write(0, 8'h12); send_byte(8'h12, 1'b1, 1'b1, 1'b1, 1'b0, "badsum d0");
        expect_write(1, 8'h13); send_byte(8'h13, 1'b1, 1'b1, 1'b1, 1'b0, "badsum d1");
        expect_write(2, 8'h03); send_byte(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, "badsum d2");
        send_byte(8'hD4, 1'b0, 1'b1, 1'b0, 1'b0, "badsum sum");
        check_status("badsum err", 1'b0, 1'b0, 1'b1);

        start_load("reload");
        send_byte(8'd3, 1'b0, 1'b1, 1'b1, 1'b0, "reload len");
        expect_write(0, 8'h12); send_byte(8'h12, 1'b1, 1'b1, 1'b1, 1'b0, "reload d0");
        expect_write(1, 8'h13); send_byte(8'h13, 1'b1, 1'b1, 1'b1, 1'b0, "reload d1");
        expect_write(2, 8'h03); send_byte(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, "reload d2");
        send_byte(8'hD5, 1'b0, 1'b1, 1'b0, 1'b1, "reload sum");
        check_status("reload done", 1'b1, 1'b0, 1'b0);
`else
        start_load("frame2");
        send_byte(8'd2, 1'b0, 1'b1, 1'b1, 1'b0, "frame2 len");
        expect_write(0, 8'hAA); send_byte(8'hAA, 1'b1, 1'b1, 1'b1, 1'b0, "frame2 d0");
        expect_write(1, 8'h55); send_byte(8'h55, 1'b1, 1'b1, 1'b0, 1'b1, "frame2 d1");
        check_status("frame2 done", 1'b1, 1'b0, 1'b0);
`endif
        // Bytes outside a load are ignored: no write, no ack
        send_byte(8'h77, 1'b0, 1'b0, 1'b0, 1'b1, "done stray");

        start_load("len0");
        send_byte(8'd0, 1'b0, 1'b1, 1'b0, 1'b0, "len0 len");
        check_status("len0 err", 1'b0, 1'b0, 1'b1);
        send_byte(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, "err stray");

        start_load("len23");
        send_byte(8'd23, 1'b0, 1'b1, 1'b0, 1'b0, "len23 len");
        check_status("len23 err", 1'b0, 1'b0, 1'b1);

        // Abort after two of five data bytes
        start_load("abort");
        send_byte(8'd5, 1'b0, 1'b1, 1'b1, 1'b0, "abort len");
        expect_write(0, 8'hA1); send_byte(8'hA1, 1'b1, 1'b1, 1'b1, 1'b0, "abort d0");
        expect_write(1, 8'hB2); send_byte(8'hB2, 1'b1, 1'b1, 1'b1, 1'b0, "abort d1");
        @(negedge clk); load_req = 1'b0;
        @(posedge clk); #1;
        check_status("abort err", 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of DATA while mem_we is high
        start_load("arst");
        send_byte(8'd3, 1'b0, 1'b1, 1'b1, 1'b0, "arst len");
        expect_write(0, 8'h11); send_byte(8'h11, 1'b1, 1'b1, 1'b1, 1'b0, "arst d0");
        expect_write(1, 8'h22); send_byte(8'h22, 1'b1, 1'b1, 1'b1, 1'b0, "arst d1");
        @(negedge clk); byte_in = 8'h33;
        @(negedge clk); strobe = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("arst pre mem_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check_status("arst", 1'b0, 1'b0, 1'b0);
        check("arst ack", 32'(ack), 32'd0);
        check("arst mem_we", 32'(mem_we), 32'd0);
        check("arst mem_waddr", 32'(mem_waddr), 32'd0);
        check("arst mem_wdata", 32'(mem_wdata), 32'd0);
        @(negedge clk); strobe = 1'b0; load_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_status("arst recover", 1'b1, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        check("pending writes", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
